// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back / write-allocate L2 cache with true-LRU replacement.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module l2_cache_wb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int CACHE_WORDS   = 1024,
  parameter int LINE_WORDS    = 16,
  parameter int NUM_WAYS      = 4,
  parameter int L1_LINE_WORDS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [L1_LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
  output logic                                resp_valid,
  output logic [L1_LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
  output logic                                resp_hit,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0]    mem_wdata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0]    mem_rdata,
  output logic                                mem_read,
  output logic                                mem_write,
  input  logic                                mem_ready,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count,
  output logic [31:0]                         wb_count
);
  localparam int SETS      = CACHE_WORDS / LINE_WORDS / NUM_WAYS;
  localparam int OFF_W     = $clog2(LINE_WORDS);
  localparam int IDX_W     = $clog2(SETS);
  localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WAY_W     = $clog2(NUM_WAYS);
  localparam int L1_OFF_W  = $clog2(L1_LINE_WORDS);
  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
  localparam int L1_BITS   = L1_LINE_WORDS * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [L1_BITS-1:0]    wdata_q;
  logic                  hit_q;
  logic [WAY_W-1:0]      way_q;

  logic [LINE_BITS-1:0] data_arr  [SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_arr   [SETS][NUM_WAYS];
  logic [WAY_W-1:0]     age_arr   [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_arr [SETS];
  logic [NUM_WAYS-1:0]  dirty_arr [SETS];

  logic [OFF_W-1:0] offset, sub;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [31:0]      sub_base;
  logic [WAY_W-1:0] old_age;

  assign offset   = addr_q[OFF_W-1:0];
  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign sub      = offset >> L1_OFF_W;
  assign sub_base = 32'(sub) * 32'(L1_BITS);
  assign old_age  = age_arr[idx][way_q];

  logic             lookup_hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim;

  // Tag compare and victim choice; descending scan lets the lowest way win.
  always_comb begin
    lookup_hit = 1'b0;
    inv_found  = 1'b0;
    hit_way    = {WAY_W{1'b0}};
    inv_way    = {WAY_W{1'b0}};
    lru_way    = {WAY_W{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      lookup_hit = (valid_arr[idx][w] && tag_arr[idx][w] == tag) ? 1'b1 : lookup_hit;
      hit_way    = (valid_arr[idx][w] && tag_arr[idx][w] == tag) ? WAY_W'(w) : hit_way;
      inv_found  = (!valid_arr[idx][w]) ? 1'b1 : inv_found;
      inv_way    = (!valid_arr[idx][w]) ? WAY_W'(w) : inv_way;
      lru_way    = (age_arr[idx][w] == WAY_W'(NUM_WAYS - 1)) ? WAY_W'(w) : lru_way;
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = {L1_BITS{1'b0}};
    resp_hit   = 1'b0;
    mem_addr   = {ADDR_WIDTH{1'b0}};
    mem_wdata  = {LINE_BITS{1'b0}};
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready  = 1'b1;
        state_next = req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        state_next = lookup_hit ? RESPOND :
                     ((valid_arr[idx][victim] && dirty_arr[idx][victim]) ? WRITEBACK : REFILL);
      end
      WRITEBACK: begin
        mem_write  = 1'b1;
        mem_addr   = {tag_arr[idx][way_q], idx, {OFF_W{1'b0}}};
        mem_wdata  = data_arr[idx][way_q];
        state_next = mem_ready ? REFILL : WRITEBACK;
      end
      REFILL: begin
        mem_read   = 1'b1;
        mem_addr   = {tag, idx, {OFF_W{1'b0}}};
        state_next = mem_ready ? RESPOND : REFILL;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_rdata = write_q ? {L1_BITS{1'b0}} : data_arr[idx][way_q][sub_base +: L1_BITS];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, request capture, valid/dirty bits and LRU ages.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      write_q <= 1'b0;
      wdata_q <= {L1_BITS{1'b0}};
      hit_q   <= 1'b0;
      way_q   <= {WAY_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= {NUM_WAYS{1'b0}};
        dirty_arr[s] <= {NUM_WAYS{1'b0}};
        for (int w = 0; w < NUM_WAYS; w++) age_arr[s][w] <= WAY_W'(w);
      end
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (state == LOOKUP) begin
        hit_q <= lookup_hit;
        way_q <= lookup_hit ? hit_way : victim;
      end
      if (state == REFILL && mem_ready) begin
        valid_arr[idx][way_q] <= 1'b1;
        dirty_arr[idx][way_q] <= 1'b0;
      end
      if (state == RESPOND) begin
        if (write_q) dirty_arr[idx][way_q] <= 1'b1;
        // Accessed way becomes MRU; only younger ways age, so ages stay a permutation.
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == way_q) age_arr[idx][w] <= {WAY_W{1'b0}};
          else if (age_arr[idx][w] < old_age) age_arr[idx][w] <= age_arr[idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // Line data and tags carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL && mem_ready) begin
      data_arr[idx][way_q] <= mem_rdata;
      tag_arr[idx][way_q]  <= tag;
    end else if (!rst && state == RESPOND && write_q) begin
      data_arr[idx][way_q][sub_base +: L1_BITS] <= wdata_q;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
      wb_cnt   <= 32'd0;
    end else begin
      if (state == RESPOND && hit_q && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      if (state == RESPOND && !hit_q && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      if (state == WRITEBACK && mem_ready && wb_cnt != 32'hFFFF_FFFF) wb_cnt <= wb_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
  assign wb_count   = wb_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
  assign wb_count   = 32'd0;
`endif

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed self-checking bench for l2_cache_wb; a second instance with 4-word L1 transfers
// runs in lockstep on the same request stream to check sub-line selection.
module tb_l2_cache_wb;
  localparam int LB = 512;
  localparam int SB = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_write, mem_ready;
  logic [31:0]   req_addr;
  logic [LB-1:0] req_wdata, mem_rdata;

  logic          req_ready, resp_valid, resp_hit, mem_read, mem_write;
  logic [LB-1:0] resp_rdata, mem_wdata;
  logic [31:0]   mem_addr, hit_count, miss_count, wb_count;

  logic          b_req_ready, b_resp_valid, b_resp_hit, b_mem_read, b_mem_write;
  logic [SB-1:0] b_resp_rdata;
  logic [LB-1:0] b_mem_wdata;
  logic [31:0]   b_mem_addr, b_hit_count, b_miss_count, b_wb_count;

  l2_cache_wb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_hit(resp_hit), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  l2_cache_wb #(.L1_LINE_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[SB-1:0]), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_hit(b_resp_hit), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_ready(mem_ready), .hit_count(b_hit_count),
    .miss_count(b_miss_count), .wb_count(b_wb_count)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [LB-1:0] r_rdata, r_wr_data;
  logic [SB-1:0] r_rdata_b;
  logic [31:0]   r_rd_addr, r_wr_addr;
  logic          r_hit, r_after;
  int            r_lat, r_nrd, r_nwr, r_both;

  function automatic logic [LB-1:0] line_pat(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = (a & 32'hFFFF_FF00) | 32'(i);
    return l;
  endfunction

  function automatic logic [LB-1:0] wpat(input logic [31:0] base);
    logic [LB-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request; acts as memory with one wait cycle before each mem_ready.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [LB-1:0] wd);
    int  cyc, wcnt;
    logic done;
    r_nrd = 0; r_nwr = 0; r_both = 0; r_lat = -1; r_hit = 1'bx;
    r_rd_addr = 32'd0; r_wr_addr = 32'd0; r_wr_data = '0; r_rdata = '0; r_rdata_b = '0;
    done = 1'b0; cyc = 0; wcnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; req_addr = 32'hDEAD_0000;
      mem_ready = 1'b0;
      if (mem_read && mem_write) r_both++;
      if (resp_valid) begin
        r_rdata = resp_rdata; r_rdata_b = b_resp_rdata; r_hit = resp_hit; r_lat = cyc; done = 1'b1;
      end else if (mem_read || mem_write) begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          mem_ready = 1'b1;
          if (mem_write) begin
            r_nwr++; r_wr_addr = mem_addr; r_wr_data = mem_wdata;
          end else begin
            r_nrd++; r_rd_addr = mem_addr; mem_rdata = line_pat(mem_addr);
          end
        end
      end
    end
    total_cnt++;
    if (!done) $display("FAIL req_timeout addr=%h got no resp_valid, expected one within 60 cycles", addr);
    else pass_cnt++;
    @(negedge clk);
    r_after = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
    total_cnt++; if ({resp_valid, resp_hit, mem_read, mem_write} !== 4'b0000)
      $display("FAIL reset_ctl got %b exp 0000", {resp_valid, resp_hit, mem_read, mem_write}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'd0 || resp_rdata !== '0 || mem_wdata !== '0)
      $display("FAIL reset_data got addr=%h exp 0 and zero data", mem_addr); else pass_cnt++;
    total_cnt++; if ({hit_count, miss_count, wb_count} !== 96'd0)
      $display("FAIL reset_counters got %h exp 0", {hit_count, miss_count, wb_count}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    apply_reset();
    do_req(1'b0, 32'h120, '0);
    total_cnt++; if (r_hit !== 1'b0) $display("FAIL cold_hit got %b exp 0", r_hit); else pass_cnt++;
    total_cnt++; if (r_nrd !== 1 || r_rd_addr !== 32'h120)
      $display("FAIL cold_refill got n=%0d addr=%h exp 1 120", r_nrd, r_rd_addr); else pass_cnt++;
    total_cnt++; if (r_rdata !== line_pat(32'h120)) $display("FAIL cold_rdata got %h exp %h", r_rdata[63:0], 64'h0000_0101_0000_0100); else pass_cnt++;
    total_cnt++; if (r_lat !== 4 || r_after !== 1'b0)
      $display("FAIL cold_latency got %0d after=%b exp 4 0", r_lat, r_after); else pass_cnt++;
    do_req(1'b0, 32'h120, '0);
    total_cnt++; if (r_hit !== 1'b1 || r_lat !== 2)
      $display("FAIL warm_hit got hit=%b lat=%0d exp 1 2", r_hit, r_lat); else pass_cnt++;
    total_cnt++; if (r_nrd + r_nwr !== 0 || r_rdata !== line_pat(32'h120))
      $display("FAIL warm_data got mem_ops=%0d exp 0 and refill data", r_nrd + r_nwr); else pass_cnt++;
  endtask

  task automatic test_write_hit();
    do_req(1'b1, 32'h120, wpat(32'hAAAA_0000));
    total_cnt++; if (r_hit !== 1'b1 || r_rdata !== '0 || r_nwr !== 0)
      $display("FAIL write_hit got hit=%b nwr=%0d exp 1 0 with zero rdata", r_hit, r_nwr); else pass_cnt++;
    do_req(1'b0, 32'h120, '0);
    total_cnt++; if (r_hit !== 1'b1 || r_rdata !== wpat(32'hAAAA_0000) || r_nwr !== 0)
      $display("FAIL write_readback got hit=%b w0=%h exp 1 aaaa0000", r_hit, r_rdata[31:0]); else pass_cnt++;
  endtask

  task automatic test_lru();
    apply_reset();
    do_req(1'b1, 32'h020, wpat(32'h5555_0000));
    do_req(1'b0, 32'h120, '0);
    do_req(1'b0, 32'h220, '0);
    do_req(1'b0, 32'h320, '0);
    do_req(1'b0, 32'h020, '0);
    total_cnt++; if (r_hit !== 1'b1) $display("FAIL lru_mru_hit got %b exp 1", r_hit); else pass_cnt++;
    do_req(1'b0, 32'h420, '0);
    total_cnt++; if (r_hit !== 1'b0 || r_nwr !== 0 || r_rd_addr !== 32'h420)
      $display("FAIL lru_evict got hit=%b nwr=%0d rd=%h exp 0 0 420", r_hit, r_nwr, r_rd_addr); else pass_cnt++;
    do_req(1'b0, 32'h020, '0);
    total_cnt++; if (r_hit !== 1'b1 || r_rdata !== wpat(32'h5555_0000))
      $display("FAIL lru_keep got hit=%b w0=%h exp 1 55550000", r_hit, r_rdata[31:0]); else pass_cnt++;
    do_req(1'b0, 32'h120, '0);
    total_cnt++; if (r_hit !== 1'b0 || r_nwr !== 0)
      $display("FAIL lru_victim_gone got hit=%b nwr=%0d exp 0 0", r_hit, r_nwr); else pass_cnt++;
  endtask

  task automatic test_dirty_evict();
    logic [31:0] exp_wb, exp_miss;
    apply_reset();
    for (int k = 0; k < 4; k++) do_req(1'b1, 32'h020 + 32'(k) * 32'h100, wpat(32'hD000_0000 + 32'(k) * 32'h100));
    do_req(1'b0, 32'h420, '0);
    total_cnt++; if (r_nwr !== 1 || r_wr_addr !== 32'h020)
      $display("FAIL dirty_wb_addr got n=%0d addr=%h exp 1 020", r_nwr, r_wr_addr); else pass_cnt++;
    total_cnt++; if (r_wr_data !== wpat(32'hD000_0000))
      $display("FAIL dirty_wb_data got w0=%h exp d0000000", r_wr_data[31:0]); else pass_cnt++;
    total_cnt++; if (r_nrd !== 1 || r_rd_addr !== 32'h420 || r_rdata !== line_pat(32'h420) || r_hit !== 1'b0)
      $display("FAIL dirty_refill got n=%0d addr=%h hit=%b exp 1 420 0", r_nrd, r_rd_addr, r_hit); else pass_cnt++;
    total_cnt++; if (r_lat !== 6 || r_both !== 0)
      $display("FAIL dirty_latency got lat=%0d both=%0d exp 6 0", r_lat, r_both); else pass_cnt++;
`ifdef PERF_COUNTERS_EN
    exp_wb = 32'd1; exp_miss = 32'd5;
`else
    exp_wb = 32'd0; exp_miss = 32'd0;
`endif
    total_cnt++; if (wb_count !== exp_wb || miss_count !== exp_miss || hit_count !== 32'd0)
      $display("FAIL perf_counters got wb=%0d miss=%0d hit=%0d exp %0d %0d 0", wb_count, miss_count, hit_count, exp_wb, exp_miss); else pass_cnt++;
  endtask

  task automatic test_subline();
    logic [LB-1:0] exp_line;
    logic [SB-1:0] exp_sub;
    apply_reset();
    exp_line = line_pat(32'h120);
    exp_sub  = exp_line[256 +: SB];
    do_req(1'b0, 32'h128, '0);
    total_cnt++; if (r_rdata_b !== exp_sub) $display("FAIL subline_rdata got %h exp %h", r_rdata_b, exp_sub); else pass_cnt++;
    total_cnt++; if (r_rdata !== exp_line || r_rd_addr !== 32'h120)
      $display("FAIL subline_full got addr=%h exp 120 with full line", r_rd_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, seen;
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h520; req_wdata = '0;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!mem_read && n < 20) begin @(negedge clk); n++; end
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL midrst_reach_refill got mem_read=%b exp 1", mem_read); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (mem_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL midrst_abort got rd=%b rv=%b rdy=%b exp 0 0 1", mem_read, resp_valid, req_ready); else pass_cnt++;
    rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_valid || mem_read) seen++; end
    total_cnt++; if (seen !== 0) $display("FAIL midrst_quiet got %0d active cycles exp 0", seen); else pass_cnt++;
    do_req(1'b0, 32'h520, '0);
    total_cnt++; if (r_hit !== 1'b0 || r_nrd !== 1) $display("FAIL midrst_remiss got hit=%b nrd=%0d exp 0 1", r_hit, r_nrd); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_lru();
    test_dirty_evict();
    test_subline();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
Parametrised set-associative, write-back, write-allocate L2 cache between the L1 cache and main memory. Adds dirty tracking, victim write-back, true-LRU replacement, sub-line (L1-sized) read/write and a valid/ready request handshake. Addresses are word addresses. Memory transfers are always full L2 lines.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 32, word-address width
CACHE_WORDS, 1024, total data capacity in words
LINE_WORDS, 16, words per L2 line (power of 2)
NUM_WAYS, 4, associativity (power of 2, ≥2)
L1_LINE_WORDS, 16, words per upstream transfer (power of 2, ≤ LINE_WORDS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  upstream request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1 = write L1 sub-line, 0 = read
req_addr  in  ADDR_WIDTH  word address; low log2(L1_LINE_WORDS) bits ignored
req_wdata  in  L1_LINE_WORDS*DATA_WIDTH  write data, word 0 in LSBs
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  L1_LINE_WORDS*DATA_WIDTH  read data; 0 for writes
resp_hit  out  1  qualified by resp_valid; 1 = hit without memory traffic
mem_addr  out  ADDR_WIDTH  line-aligned address
mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line
mem_rdata  in  LINE_WORDS*DATA_WIDTH  refill line
mem_read  out  1  refill request, level
mem_write  out  1  write-back request, level
mem_ready  in  1  one-cycle completion; mem_rdata is sampled in this cycle
hit_count, miss_count, wb_count  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Geometry: SETS = CACHE_WORDS/LINE_WORDS/NUM_WAYS. offset = addr[log2(LINE_WORDS)-1:0]. index = next log2(SETS) bits. tag = remainder.
- Sub-line select: sub = offset >> log2(L1_LINE_WORDS).
- Reset (synchronous): state=IDLE. All valid, dirty cleared. LRU age of way w = w. All outputs 0 except req_ready=1. Reset mid-transaction abandons it immediately: mem_read/mem_write drop at the same edge and no resp_valid is issued.
- Request capture: a request is accepted on req_valid & req_ready. addr, write flag and wdata are registered. Inputs are ignored until the next IDLE.
- FSM: IDLE -> LOOKUP -> (hit) RESPOND. On a miss: LOOKUP -> WRITEBACK (victim valid & dirty) or REFILL (otherwise). WRITEBACK -> REFILL. REFILL -> RESPOND. RESPOND -> IDLE.
- LOOKUP: tag compare across all ways. A hit on multiple ways cannot occur; the lowest way wins if it does.
- Victim selection: the lowest-index invalid way. If every way is valid, the way whose age = NUM_WAYS-1.
- WRITEBACK: mem_write=1 and mem_addr={victim tag,index,0}. mem_wdata holds the victim line until mem_ready.
- REFILL: mem_read=1 and mem_addr={tag,index,0} until mem_ready. On mem_ready: install the line, set valid, clear dirty, set the tag.
- RESPOND, read: resp_rdata = words [sub*L1_LINE_WORDS +: L1_LINE_WORDS] of the line.
- RESPOND, write: that sub-line is overwritten with req_wdata and dirty is set; resp_rdata=0.
- RESPOND, all requests: resp_valid=1 for exactly one cycle. resp_hit = lookup result.
- LRU update in RESPOND: the accessed way's age goes to 0. Ways whose age was below the old age increment by 1. Other ways are unchanged. Ages stay a permutation of 0..NUM_WAYS-1.
- Latency: accept at cycle 0, LOOKUP at cycle 1, hit resp_valid at cycle 2. Miss latency = 2 + the mem_ready waits (+1 per memory phase).
- mem_ready outside WRITEBACK/REFILL is ignored. mem_read and mem_write are never both high.
- A write hit on a clean line makes it dirty. A read never changes dirty.

Optional Feature:
PERF_COUNTERS_EN
- Defined: hit_count and miss_count increment in RESPOND according to resp_hit. wb_count increments on each WRITEBACK mem_ready. All three saturate at 0xFFFF_FFFF and clear on rst.
- Undefined: all three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Cold read at addr 0x120 (index 2, tag 1), memory returns words 0x100..0x10F -> mem_read with mem_addr=0x120. resp_rdata words 0..15 = 0x100..0x10F, resp_hit=0. Repeat the read -> resp_valid at cycle 2, resp_hit=1, no memory activity.
- Write 0xAAAA_0000+i to 0x120, then read 0x120 -> read returns the written data with resp_hit=1. No mem_write occurs until eviction.
- LRU eviction: write 0x020, then read 0x120, 0x220, 0x320, then read 0x020 again (0x020 becomes MRU), then read 0x420 -> victim is the line at 0x120 (clean), so no mem_write. Then read 0x020 -> hit.
- Dirty eviction: fill set 2 with four writes (0x020..0x320), then read 0x420 -> mem_write with mem_addr=0x020 and the written data. Then mem_read 0x420. wb_count=1 when PERF_COUNTERS_EN is defined.
- Sub-line: with L1_LINE_WORDS=4, read 0x128 -> resp_rdata = line words 8..11.
- Assert rst while mem_read is high in REFILL -> mem_read=0 next cycle, no resp_valid, the following read of the same address misses.
